// File: rtl/hazard_unit.sv
// hazard_unit
//   Hazard and forwarding controller for the 5-stage MIPS pipeline. It sits
//   beside ID and decides what enters the ID->EX register each cycle. It keeps
//   shadow copies of the EX and MEM destination state, so the downstream
//   pipeline registers do not need to feed anything back to it.
//
//   Optional feature macro: HAZARD_PERF_CNT_EN adds the lu_stall_count and
//   mem_wait_count performance counters.
//
// Ports
//   clock              rising-edge clock
//   reset_0            synchronous, active-low reset
//   rs_id, rt_id       ID source registers; use_rs_id/use_rt_id mark real reads
//   rw_id              ID destination; wreg_id = writes regfile, rmem_id = load
//   branch_taken_id    ID resolved a taken branch/jump this cycle
//   mem_busy           data memory not ready
//   fwd_a, fwd_b       operand select: 00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM load
//   stall_pc/ifid      hold PC and IF/ID
//   bubble_idex        load zero control into ID->EX
//   flush_ifid         load a nop into IF/ID
//   hold_pipe          freeze every pipeline register
//   mem_timeout        sticky: memory wait reached MEM_TIMEOUT cycles
//   lu_stall_count     (HAZARD_PERF_CNT_EN) cycles spent in load-use stall
//   mem_wait_count     (HAZARD_PERF_CNT_EN) cycles with hold_pipe high
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_RUN  | memory ready, pipeline advancing normally
// ST_WAIT | memory busy was seen; counting consecutive wait cycles
module hazard_unit #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset_0,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic        use_rs_id,
    input  logic        use_rt_id,
    input  logic [4:0]  rw_id,
    input  logic        wreg_id,
    input  logic        rmem_id,
    input  logic        branch_taken_id,
    input  logic        mem_busy,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        stall_pc,
    output logic        stall_ifid,
    output logic        bubble_idex,
    output logic        flush_ifid,
    output logic        hold_pipe,
    output logic        mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] lu_stall_count,
    output logic [31:0] mem_wait_count
`endif
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

    typedef enum logic {ST_RUN, ST_WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;

    logic [4:0] ex_rw_q, ex_rw_d, mem_rw_q, mem_rw_d;
    logic       ex_wreg_q, ex_wreg_d, mem_wreg_q, mem_wreg_d;
    logic       ex_rmem_q, ex_rmem_d, mem_rmem_q, mem_rmem_d;

    logic ex_ma, ex_mb, mem_ma, mem_mb;
    logic lu, hold, bubble;

    // Register 0 is hardwired, so a write to it never creates a dependency.
    function automatic logic match(input logic [4:0] rw, input logic wreg,
                                   input logic [4:0] src, input logic use_src);
        return wreg && (rw != 5'd0) && (rw == src) && use_src;
    endfunction

    // EX wins over MEM; an EX load cannot forward (that case is the load-use
    // stall), so it falls through to whatever MEM holds.
    function automatic logic [1:0] fwd_sel(input logic ex_m, input logic ex_ld,
                                           input logic mem_m, input logic mem_ld);
        if (ex_m && !ex_ld)
            return 2'b01;
        else if (mem_m)
            return mem_ld ? 2'b11 : 2'b10;
        else
            return 2'b00;
    endfunction

    assign ex_ma  = match(ex_rw_q,  ex_wreg_q,  rs_id, use_rs_id);
    assign ex_mb  = match(ex_rw_q,  ex_wreg_q,  rt_id, use_rt_id);
    assign mem_ma = match(mem_rw_q, mem_wreg_q, rs_id, use_rs_id);
    assign mem_mb = match(mem_rw_q, mem_wreg_q, rt_id, use_rt_id);

    always_comb begin
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        lu          = 1'b0;
        hold        = 1'b0;
        bubble      = 1'b0;
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        flush_ifid  = 1'b0;
        if (reset_0) begin
            fwd_a      = fwd_sel(ex_ma, ex_rmem_q, mem_ma, mem_rmem_q);
            fwd_b      = fwd_sel(ex_mb, ex_rmem_q, mem_mb, mem_rmem_q);
            lu         = (ex_ma || ex_mb) && ex_rmem_q;
            hold       = mem_busy;
            // A memory hold freezes everything, so it suppresses the bubble;
            // the load-use check simply repeats once the hold releases.
            bubble     = lu && !hold;
            stall_pc   = lu || hold;
            stall_ifid = lu || hold;
            // A branch resolved during a load-use stall used stale operands.
            flush_ifid = branch_taken_id && !lu && !hold;
        end
    end

    assign bubble_idex = bubble;
    assign hold_pipe   = hold;
    assign mem_timeout = tmo_q && reset_0;

    always_comb begin
        ex_rw_d    = ex_rw_q;
        ex_wreg_d  = ex_wreg_q;
        ex_rmem_d  = ex_rmem_q;
        mem_rw_d   = mem_rw_q;
        mem_wreg_d = mem_wreg_q;
        mem_rmem_d = mem_rmem_q;
        if (!hold) begin
            mem_rw_d   = ex_rw_q;
            mem_wreg_d = ex_wreg_q;
            mem_rmem_d = ex_rmem_q;
            ex_rw_d    = bubble ? 5'd0 : rw_id;
            ex_wreg_d  = bubble ? 1'b0 : wreg_id;
            ex_rmem_d  = bubble ? 1'b0 : rmem_id;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        case (state_q)
            ST_RUN: begin
                cnt_d = '0;
                if (mem_busy)
                    state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_busy) begin
                    if (cnt_q != TMO)
                        cnt_d = cnt_q + CW'(1);
                end else begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
        if (cnt_d == TMO)
            tmo_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset_0) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            tmo_q      <= 1'b0;
            ex_rw_q    <= 5'd0;
            ex_wreg_q  <= 1'b0;
            ex_rmem_q  <= 1'b0;
            mem_rw_q   <= 5'd0;
            mem_wreg_q <= 1'b0;
            mem_rmem_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            ex_rw_q    <= ex_rw_d;
            ex_wreg_q  <= ex_wreg_d;
            ex_rmem_q  <= ex_rmem_d;
            mem_rw_q   <= mem_rw_d;
            mem_wreg_q <= mem_wreg_d;
            mem_rmem_q <= mem_rmem_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lu_cnt_q, lu_cnt_d, wait_cnt_q, wait_cnt_d;

    assign lu_cnt_d   = lu_cnt_q   + 32'(bubble);
    assign wait_cnt_d = wait_cnt_q + 32'(hold);

    always_ff @(posedge clock) begin
        if (!reset_0) begin
            lu_cnt_q   <= 32'd0;
            wait_cnt_q <= 32'd0;
        end else begin
            lu_cnt_q   <= lu_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign lu_stall_count = lu_cnt_q;
    assign mem_wait_count = wait_cnt_q;
`endif

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard and forwarding controller for the 5-stage MIPS CPU. Sits beside the ID stage and decides what enters the ID->EX register each cycle: forwarding selects for the a/b operands, load-use stall and bubble, branch flush of IF/ID, and whole-pipe freeze while data memory is busy. Tracks its own shadow copy of the EX and MEM destination state, so it needs no feedback from the downstream pipeline registers.

## Interface
- MEM_TIMEOUT, 16: consecutive mem_busy cycles after which mem_timeout sets.
- clock  in  1  rising-edge clock.
- reset_0  in  1  synchronous, active-low reset.
- rs_id, rt_id  in  5 each  source register numbers of the ID instruction.
- use_rs_id, use_rt_id  in  1 each  ID instruction actually reads rs / rt.
- rw_id  in  5  destination register of the ID instruction.
- wreg_id, rmem_id  in  1 each  ID instruction writes the register file / is a load.
- branch_taken_id  in  1  ID resolved a taken branch or jump this cycle.
- mem_busy  in  1  data memory not ready; MEM stage cannot complete.
- fwd_a, fwd_b  out  2 each  operand select: 00 register file, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data.
- stall_pc, stall_ifid  out  1 each  hold PC / IF-ID register.
- bubble_idex  out  1  load all-zero control into ID->EX.
- flush_ifid  out  1  load a nop into IF/ID.
- hold_pipe  out  1  freeze every pipeline register, including ID->EX, EX->MEM and MEM->WB.
- mem_timeout  out  1  sticky error flag.

## Operation
- Shadow state: ex_s = {rw, wreg, rmem}, mem_s = {rw, wreg, rmem}.
- Match rule: a stage matches operand X when its wreg = 1, its rw != 0, its rw == X, and use_X = 1. Register 0 never matches.
- Load-use (lu): ex_s matches rs or rt and ex_s.rmem = 1.
  - Outputs: stall_pc = stall_ifid = bubble_idex = 1.
  - flush_ifid = 0, even if branch_taken_id = 1. The branch decision used stale operands; it is re-evaluated after the stall.
- Forwarding, per operand:
  - 01 if ex_s matches and ex_s.rmem = 0.
  - Otherwise 11 if mem_s matches and mem_s.rmem = 1; 10 if mem_s matches and mem_s.rmem = 0.
  - Otherwise 00.
  - EX takes priority over MEM.
- flush_ifid = branch_taken_id & ~lu & ~hold_pipe.
- FSM states:
  - RUN: no hold. Moves to WAIT when mem_busy = 1 at a clock edge.
  - WAIT: entered the cycle after mem_busy is first sampled high. Moves back to RUN when mem_busy = 0 at a clock edge.
  - hold_pipe = mem_busy, combinational, in both states.
  - While hold_pipe = 1: stall_pc = stall_ifid = 1; bubble_idex = 0, flush_ifid = 0; shadows do not advance. fwd_* continue to reflect the current shadows.
- Wait counter:
  - Counts consecutive cycles in WAIT and saturates at MEM_TIMEOUT.
  - mem_timeout sets when the count reaches MEM_TIMEOUT and stays set until reset.
  - The count clears on return to RUN.
- Shadow advance, on a clock edge with hold_pipe = 0: mem_s <= ex_s; ex_s <= bubble_idex ? 0 : {rw_id, wreg_id, rmem_id}.

## Timing
- Reset (reset_0 = 0 at an edge) sets: shadows = 0, state = RUN, wait counter = 0, mem_timeout = 0.
- While reset_0 = 0, all outputs are forced to 0 combinationally: fwd_* = 00, stalls/bubble/flush/hold = 0.
- Reset asserted mid-WAIT or mid-stall aborts it at the next edge; no residual stall afterwards.
- All hazard, forward and flush outputs are combinational from the current shadows and ID inputs; zero-cycle latency.
- A load-use stall lasts exactly 1 cycle. The next cycle the load is in mem_s, so the operand select is 11 with no stall.
- Back-to-back: a load followed by two dependent instructions gives one stall; the second consumer gets 10/11 or 00 per the normal rules.
- mem_busy asserted together with a load-use hazard: hold_pipe wins and bubble_idex = 0. The load-use condition is re-evaluated after the hold releases.
- mem_timeout asserts on the edge that the counter reaches MEM_TIMEOUT.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds output ports lu_stall_count (32) and mem_wait_count (32).
  - lu_stall_count increments each cycle in which the load-use stall is in effect (lu = 1, hold_pipe = 0).
  - mem_wait_count increments each cycle with hold_pipe = 1.
  - Both wrap at 2^32 and clear on reset.
- HAZARD_PERF_CNT_EN undefined: the ports and counters do not exist; all other behaviour is identical.

## Test plan
- ALU forward: cycle 0 ID rw=5, wreg=1, rmem=0. Cycle 1 ID rs=5, use_rs=1 -> fwd_a = 01, no stall. Cycle 2 ID rt=5, use_rt=1 -> fwd_b = 10.
- Load-use: ID load rw=8. Next ID rs=8, use_rs=1 -> stall_pc = stall_ifid = bubble_idex = 1 for exactly 1 cycle. The following cycle fwd_a = 11, stalls = 0.
- r0 and priority:
  - ex_s.rw = 0 with wreg = 1, rs = 0 -> fwd_a = 00.
  - EX and MEM both write r3, rs = 3 -> fwd_a = 01.
- Branch vs load-use: branch_taken_id = 1 together with a load-use hazard -> flush_ifid = 0, bubble = 1. Next cycle branch_taken_id = 1 alone -> flush_ifid = 1.
- Memory wait:
  - mem_busy high for 20 cycles with MEM_TIMEOUT = 16 -> hold_pipe = 1 for all 20 cycles and shadows unchanged; mem_timeout sets on the 16th edge in WAIT and stays set after mem_busy drops.
  - With HAZARD_PERF_CNT_EN defined: mem_wait_count = 20.
- Reset mid-WAIT: reset_0 low for one edge during WAIT -> next cycle state = RUN, mem_timeout = 0, all outputs 0 with idle inputs.
